ysyx_23060061_lsu_fsm: RTL and testbench

//  Load/store stage between the decode/execute stage and WBU. Accepts one op per valid/ready

---
 rtl/ysyx_23060061_lsu_fsm.sv | 232 +++++++++++++++++++++++
 tb/tb_ysyx_23060061_lsu_fsm.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060061_lsu_fsm.sv
// -----------------------------------------------------------------------------
// ysyx_23060061_lsu_fsm
//
// Load/store stage sitting between the execute stage and WBU. It takes one op
// per in_valid/in_ready handshake. For a load or store it issues one request on
// a req/resp data-memory port and waits for the response. It then aligns and
// extends the load data. The finished result is held for WBU until out_ready.
// Non-memory ops pass straight to the result register with one cycle latency.
//
// Configuration macro:
//   LSU_MISALIGN_CHECK_EN  when defined, misaligned halfword/word accesses
//                          issue no memory request. They complete
//                          immediately with lsu_err=1 and memDataR=0.
//                          Undefined: no check is made. Misaligned lanes are
//                          simply truncated at the word boundary.
//
// Parameters:
//   TIMEOUT   number of WAIT cycles before an access is aborted with lsu_err=1.
//             A value of 0 means the access never times out.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   in_valid / in_ready      op handshake from the execute stage
//   MemRW                    00 none, 01 load, 10 store, 11 none
//   memExt                   load extend: LW, LH, LHU, LB, LBU (others = LW)
//   memAddr, memDataW, wmask byte address, right-justified store data/mask
//   aluOut_in, snpc_in, WBSel_in   passed through to the *_out registers
//   mem_req_*                request channel (valid/ready, wen, addr, wdata, wmask)
//   mem_resp_valid, mem_rdata      response channel (load data or store ack)
//   out_valid / out_ready    result handshake to WBU
//   memDataR                 aligned, extended load data (0 for non-loads)
//   aluOut_out, snpc_out, WBSel_out  registered copies of the inputs
//   lsu_err                  access aborted (timeout or misaligned)
// -----------------------------------------------------------------------------
module ysyx_23060061_lsu_fsm #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  MemRW,
  input  logic [2:0]  memExt,
  input  logic [31:0] memAddr,
  input  logic [31:0] memDataW,
  input  logic [3:0]  wmask,
  input  logic [31:0] aluOut_in,
  input  logic [31:0] snpc_in,
  input  logic [1:0]  WBSel_in,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,

  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] memDataR,
  output logic [31:0] aluOut_out,
  output logic [31:0] snpc_out,
  output logic [1:0]  WBSel_out,
  output logic        lsu_err
);

  // FSM encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  localparam logic [2:0] EXT_LH  = 3'd1;
  localparam logic [2:0] EXT_LHU = 3'd2;
  localparam logic [2:0] EXT_LB  = 3'd3;
  localparam logic [2:0] EXT_LBU = 3'd4;

  // The wait counter only needs to count up to TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [1:0]       state;
  logic [CNT_W-1:0] waitCnt;

  // Captured request fields. They stay stable for the whole REQ phase.
  logic             reqWen;
  logic [31:0]      reqAddr;
  logic [31:0]      reqData;
  logic [3:0]       reqMask;
  logic [2:0]       extSel;

  logic             isMemOp;
  logic             misaligned;
  logic [31:0]      shifted;
  logic [31:0]      loadData;

  // ---------------------------------------------------------------------------
  // Op classification on the incoming op (used only at the IDLE handshake).
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    isMemOp    = (MemRW == MEM_LOAD) || (MemRW == MEM_STORE);
    misaligned = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    // Stores take their access size from the lane mask; loads from memExt.
    // Byte accesses (and unusual store masks) can never be misaligned.
    if (MemRW == MEM_STORE) begin
      if (wmask == 4'b1111)
        misaligned = memAddr[1:0] != 2'b00;
      else if (wmask == 4'b0011)
        misaligned = memAddr[0];
    end else if (MemRW == MEM_LOAD) begin
      unique case (memExt)
        EXT_LH, EXT_LHU: misaligned = memAddr[0];
        EXT_LB, EXT_LBU: misaligned = 1'b0;
        default:         misaligned = memAddr[1:0] != 2'b00;
      endcase
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Load alignment/extension. Lanes above the addressed byte shift in as
  // zeros, so a misaligned access never reaches into the next word.
  // ---------------------------------------------------------------------------
  always_comb begin
    shifted = mem_rdata >> {reqAddr[1:0], 3'b000};
    unique case (extSel)
      EXT_LB:  loadData = {{24{shifted[7]}}, shifted[7:0]};
      EXT_LBU: loadData = {24'd0, shifted[7:0]};
      EXT_LH:  loadData = {{16{shifted[15]}}, shifted[15:0]};
      EXT_LHU: loadData = {16'd0, shifted[15:0]};
      default: loadData = shifted;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake and request outputs, all derived from state and captured
  // registers. They are therefore 0 and stable out of reset.
  // ---------------------------------------------------------------------------
  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == DONE);
  assign mem_req_valid = (state == REQ);
  assign mem_req_wen   = reqWen;
  assign mem_req_addr  = {reqAddr[31:2], 2'b00};
  assign mem_req_wdata = reqData << {reqAddr[1:0], 3'b000};
  assign mem_req_wmask = reqMask << reqAddr[1:0];

  // ---------------------------------------------------------------------------
  // Main FSM and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      waitCnt    <= '0;
      reqWen     <= 1'b0;
      reqAddr    <= '0;
      reqData    <= '0;
      reqMask    <= '0;
      extSel     <= '0;
      memDataR   <= '0;
      aluOut_out <= '0;
      snpc_out   <= '0;
      WBSel_out  <= '0;
      lsu_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, whatever the statement order.
            reqWen     <= (MemRW == MEM_STORE);
            reqAddr    <= memAddr;
            reqData    <= memDataW;
            reqMask    <= wmask;
            extSel     <= memExt;
            aluOut_out <= aluOut_in;
            snpc_out   <= snpc_in;
            WBSel_out  <= WBSel_in;
            memDataR   <= '0;
            lsu_err    <= 1'b0;
            if (!isMemOp) begin
              state <= DONE;
            end else if (misaligned) begin
              lsu_err <= 1'b1;
              state   <= DONE;
            end else begin
              state <= REQ;
            end
          end
        end

        REQ: begin
          if (mem_req_ready) begin
            waitCnt <= '0;
            state   <= WAIT;
          end
        end

        WAIT: begin
          // A response wins over a timeout that expires in the same cycle.
          if (mem_resp_valid) begin
            if (!reqWen)
              memDataR <= loadData;
            state <= DONE;
          end else if ((TIMEOUT != 0) && (waitCnt == CNT_LAST)) begin
            lsu_err  <= 1'b1;
            memDataR <= '0;
            state    <= DONE;
          end else begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
        end

        DONE: begin
          if (out_ready)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_lsu_fsm.sv
// -----------------------------------------------------------------------------
// tb_ysyx_23060061_lsu_fsm
//
// Self-checking bench for the LSU FSM. The bench plays the memory and WBU
// sides itself. Expected request fields, load results, error flags and
// handshake timing are computed from the stage's rules with plain arithmetic.
// The DUT runs with TIMEOUT=8 so that aborted accesses stay short.
// -----------------------------------------------------------------------------
module tb_ysyx_23060061_lsu_fsm;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  MemRW;
  logic [2:0]  memExt;
  logic [31:0] memAddr;
  logic [31:0] memDataW;
  logic [3:0]  wmask;
  logic [31:0] aluOut_in;
  logic [31:0] snpc_in;
  logic [1:0]  WBSel_in;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] memDataR;
  logic [31:0] aluOut_out;
  logic [31:0] snpc_out;
  logic [1:0]  WBSel_out;
  logic        lsu_err;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  ysyx_23060061_lsu_fsm #(.TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .MemRW          (MemRW),
    .memExt         (memExt),
    .memAddr        (memAddr),
    .memDataW       (memDataW),
    .wmask          (wmask),
    .aluOut_in      (aluOut_in),
    .snpc_in        (snpc_in),
    .WBSel_in       (WBSel_in),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_wen    (mem_req_wen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .memDataR       (memDataR),
    .aluOut_out     (aluOut_out),
    .snpc_out       (snpc_out),
    .WBSel_out      (WBSel_out),
    .lsu_err        (lsu_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference rules
  // ---------------------------------------------------------------------------
  // Load result: drop the low (addr%4) bytes, then keep and extend the
  // requested width.
  function automatic logic [31:0] exp_load(input logic [2:0] ext, input logic [31:0] addr,
                                           input logic [31:0] raw);
    logic [31:0] s;
    s = raw >> (8 * (addr % 4));
    case (ext)
      3'd1:    return s[15] ? ((s & 32'h0000FFFF) | 32'hFFFF0000) : (s & 32'h0000FFFF);
      3'd2:    return s & 32'h0000FFFF;
      3'd3:    return s[7] ? ((s & 32'h000000FF) | 32'hFFFFFF00) : (s & 32'h000000FF);
      3'd4:    return s & 32'h000000FF;
      default: return s;
    endcase
  endfunction

  // Access size in bytes: stores from the lane mask, loads from memExt.
  function automatic int access_size(input logic [1:0] rw, input logic [2:0] ext,
                                     input logic [3:0] wm);
    if (rw == 2'b10)
      return (wm == 4'hF) ? 4 : (wm == 4'h3) ? 2 : 1;
    else
      return (ext == 3'd1 || ext == 3'd2) ? 2 : (ext == 3'd3 || ext == 3'd4) ? 1 : 4;
  endfunction

  function automatic bit exp_misaligned(input logic [1:0] rw, input logic [2:0] ext,
                                        input logic [3:0] wm, input logic [31:0] addr);
    int sz;
    sz = access_size(rw, ext, wm);
`ifdef LSU_MISALIGN_CHECK_EN
    return (addr % sz) != 0;
`else
    return (sz < 0) && (addr == 0);
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // One complete op. respDelay < 0 means the memory never answers.
  // ---------------------------------------------------------------------------
  task automatic do_op(input logic [1:0] rw, input logic [2:0] ext, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] wm, input logic [31:0] alu,
                       input logic [31:0] snpc, input logic [1:0] wbs, input logic [31:0] rdata,
                       input int reqDelay, input int respDelay, input int hold);
    bit          isMem;
    bit          mis;
    logic [31:0] expData;
    logic        expErr;
    isMem   = (rw == 2'b01) || (rw == 2'b10);
    mis     = isMem && exp_misaligned(rw, ext, wm, addr);
    expData = 32'd0;
    expErr  = 1'b0;

    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    MemRW     = rw;
    memExt    = ext;
    memAddr   = addr;
    memDataW  = wd;
    wmask     = wm;
    aluOut_in = alu;
    snpc_in   = snpc;
    WBSel_in  = wbs;
    // A stray response while idle must be ignored.
    mem_resp_valid = 1'($urandom_range(0, 1));
    mem_rdata      = $urandom;
    @(negedge clk);
    // Scramble the inputs so that only the captured copy can be correct.
    in_valid       = 1'b0;
    mem_resp_valid = 1'b0;
    MemRW     = 2'($urandom);
    memExt    = 3'($urandom);
    memAddr   = $urandom;
    memDataW  = $urandom;
    wmask     = 4'($urandom);
    aluOut_in = $urandom;
    snpc_in   = $urandom;
    WBSel_in  = 2'($urandom);

    if (isMem && !mis) begin
      for (int i = 0; i <= reqDelay; i++) begin
        check("req_valid", {31'd0, mem_req_valid}, 32'd1);
        check("req_addr", mem_req_addr, addr & 32'hFFFF_FFFC);
        check("req_wdata", mem_req_wdata, wd << (8 * (addr % 4)));
        check("req_wmask", {28'd0, mem_req_wmask}, ({28'd0, wm} << (addr % 4)) & 32'hF);
        check("req_wen", {31'd0, mem_req_wen}, {31'd0, rw == 2'b10});
        check("out_valid_req", {31'd0, out_valid}, 32'd0);
        if (i == reqDelay) mem_req_ready = 1'b1;
        @(negedge clk);
      end
      mem_req_ready = 1'b0;
      check("req_drop", {31'd0, mem_req_valid}, 32'd0);
      if (respDelay < 0) begin
        for (int i = 0; i < TMO; i++) begin
          check("out_valid_wait", {31'd0, out_valid}, 32'd0);
          @(negedge clk);
        end
        expErr = 1'b1;
      end else begin
        for (int i = 0; i < respDelay; i++) begin
          check("out_valid_wait", {31'd0, out_valid}, 32'd0);
          @(negedge clk);
        end
        mem_resp_valid = 1'b1;
        mem_rdata      = rdata;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_rdata      = $urandom;
        if (rw == 2'b01) expData = exp_load(ext, addr, rdata);
      end
    end else begin
      check("no_req", {31'd0, mem_req_valid}, 32'd0);
      expErr = mis;
    end

    // Result phase: held stable until WBU accepts it; stray responses ignored.
    for (int i = 0; i <= hold; i++) begin
      check("out_valid", {31'd0, out_valid}, 32'd1);
      check("in_ready_busy", {31'd0, in_ready}, 32'd0);
      check("memDataR", memDataR, expData);
      check("lsu_err", {31'd0, lsu_err}, {31'd0, expErr});
      check("aluOut_out", aluOut_out, alu);
      check("snpc_out", snpc_out, snpc);
      check("WBSel_out", {30'd0, WBSel_out}, {30'd0, wbs});
      if (i == hold) begin
        out_ready = 1'b1;
      end else begin
        mem_resp_valid = 1'($urandom_range(0, 1));
        mem_rdata      = $urandom;
      end
      @(negedge clk);
      mem_resp_valid = 1'b0;
    end
    out_ready = 1'b0;
    check("out_valid_clear", {31'd0, out_valid}, 32'd0);
    check("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0; MemRW = '0; memExt = '0; memAddr = '0; memDataW = '0; wmask = '0;
    aluOut_in = '0; snpc_in = '0; WBSel_in = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_req_addr", mem_req_addr, 32'd0);
    check("rst_req_wmask", {28'd0, mem_req_wmask}, 32'd0);
    check("rst_memDataR", memDataR, 32'd0);
    check("rst_lsu_err", {31'd0, lsu_err}, 32'd0);
    check("rst_aluOut", aluOut_out, 32'd0);

    // Directed cases
    do_op(2'b01, 3'd0, 32'h8000_0004, 32'd0, 4'hF, 32'h11, 32'h8000_0104, 2'd1,
          32'hDEAD_BEEF, 0, 2, 0);
    do_op(2'b01, 3'd3, 32'h8000_0003, 32'd0, 4'h1, 32'h22, 32'h8000_0108, 2'd1,
          32'h8011_2233, 1, 0, 1);
    do_op(2'b01, 3'd4, 32'h8000_0003, 32'd0, 4'h1, 32'h33, 32'h8000_010C, 2'd1,
          32'h8011_2233, 0, 1, 0);
    do_op(2'b10, 3'd0, 32'h8000_0002, 32'h0000_ABCD, 4'h3, 32'h44, 32'h8000_0110, 2'd0,
          32'd0, 2, 0, 0);
    do_op(2'b00, 3'd0, 32'h0, 32'h0, 4'h0, 32'h0000_1234, 32'h8000_0114, 2'd2,
          32'd0, 0, 0, 4);
    do_op(2'b01, 3'd0, 32'h8000_0008, 32'd0, 4'hF, 32'h55, 32'h8000_0118, 2'd1,
          32'd0, 0, -1, 1);
    do_op(2'b01, 3'd0, 32'h8000_0001, 32'd0, 4'hF, 32'h66, 32'h8000_011C, 2'd1,
          32'hA5B6_C7D8, 0, 1, 0);
    do_op(2'b01, 3'd1, 32'h8000_0002, 32'd0, 4'h3, 32'h77, 32'h8000_0120, 2'd1,
          32'h8123_4567, 0, TMO - 1, 0);

    // Reset in the middle of WAIT, followed by a stray response
    in_valid = 1'b1; MemRW = 2'b01; memExt = 3'd0; memAddr = 32'h8000_0010; wmask = 4'hF;
    @(negedge clk);
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("rst_wait_pre_req", {31'd0, mem_req_valid}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_async_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_async_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_async_req_valid", {31'd0, mem_req_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("rst_stray_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_stray_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_stray_memDataR", memDataR, 32'd0);

    // Randomized ops
    for (int n = 0; n < 150; n++) begin
      logic [1:0]  rw;
      logic [3:0]  wm;
      int          pick;
      int          rd;
      rw   = 2'($urandom);
      pick = $urandom_range(0, 2);
      wm   = (pick == 0) ? 4'h1 : (pick == 1) ? 4'h3 : 4'hF;
      rd   = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, TMO - 1);
      do_op(rw, 3'($urandom), $urandom, $urandom, wm, $urandom, $urandom, 2'($urandom),
            $urandom, $urandom_range(0, 3), rd, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nErrors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
